// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch conditioning stage.
// Optional build macro SWITCH_DEBOUNCE_BYPASS_EN is consumed by debounce_bit.
package switch_pkg;

    localparam int SWITCH_WIDTH          = 8;
    localparam int DEFAULT_STABLE_CYCLES = 100000;

    // Counter width able to hold 0..stable_cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser, bounce filter, level register and edge pulses.
// Define SWITCH_DEBOUNCE_BYPASS_EN to drop the filter and pass the synchronised level straight through.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic db_q, db_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

`ifndef SWITCH_DEBOUNCE_BYPASS_EN
    localparam int                CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        s1_d = sw;
        s2_d = s1_q;
        db_d = db_q;
`ifdef SWITCH_DEBOUNCE_BYPASS_EN
        db_d = s2_q;
`else
        cnt_d = cnt_q;
        // Any reversal back to the held level restarts the stability window.
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
`endif
        // Pulses are registered alongside the level so they line up with the new db value.
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`ifndef SWITCH_DEBOUNCE_BYPASS_EN
            cnt_q  <= '0;
`endif
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
`ifndef SWITCH_DEBOUNCE_BYPASS_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign db   = db_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches bit by bit; wiring only around debounce_bit.
// Honours SWITCH_DEBOUNCE_BYPASS_EN through the per-bit instances.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH         = SWITCH_WIDTH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .sw   (switch[i]),
            .db   (switch_db[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule
